// File: rtl/iram_pkg.sv
// Shared definitions for the programmable instruction RAM: controller states,
// the NOP encoding returned on blocked fetches, and a constant log2 helper.
package iram_pkg;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    // Instruction encoding driven on Q whenever a fetch is not allowed.
    localparam int NOP = 0;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/iram_array.sv
// DEPTH x DATA_W storage with one write port and one asynchronous read port.
// Any fetch-side output register lives in the parent.
module iram_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int IW     = 7
) (
    input  logic              CLK,
    input  logic              i_we,
    input  logic [IW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Single write port; the parent decides who owns it in each state.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/prog_iram.sv
// Programmable instruction RAM: zeroes itself after reset, accepts a program
// over a valid/ready load port, then serves byte-addressed fetches.
module prog_iram
    import iram_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 128,
    parameter int ADDR_W   = 8,
    parameter int READ_REG = 0,
    localparam int IW      = clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Q,
    output logic              MISALIGN,
    output logic              OOR,
    input  logic              LD_VALID,
    output logic              LD_READY,
    input  logic [IW-1:0]     LD_ADDR,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              LD_LAST,
    output logic              BUSY,
    output logic              PROG_OK,
    output logic [IW:0]       LD_CNT
);

    // Byte-offset bits within one instruction word.
    localparam int SH = clog2(DATA_W / 8);

    state_t            r_state;
    state_t            w_state_next;
    logic [IW-1:0]     r_clr_ptr;
    logic [IW:0]       r_ld_cnt;

    logic              w_we;
    logic [IW-1:0]     w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic [DATA_W-1:0] w_q;
    logic              w_busy;
    logic              w_ld_ready;
    logic              w_prog_ok;

    // Word index carries one spare top bit so the range test below is valid
    // even when ADDR is exactly as wide as the word index.
    logic [ADDR_W:0]   w_wi;
    logic              w_mis;
    logic              w_oor;

    assign w_wi  = {1'b0, ADDR} >> SH;
    // DEPTH is a power of two, so WI >= DEPTH means any bit above the index is set.
    assign w_oor = |w_wi[ADDR_W:IW];

    generate
        if (SH > 0) begin : g_mis
            assign w_mis = |ADDR[SH-1:0];
        end else begin : g_no_mis
            assign w_mis = 1'b0;
        end
    endgenerate

    iram_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .CLK     (CLK),
        .i_we    (w_we & ~RESET),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_wi[IW-1:0]),
        .o_rdata (w_rdata)
    );

    // State register; reset always restarts the clear sweep.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, write-port ownership and status outputs.
    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_waddr      = r_clr_ptr;
        w_wdata      = DATA_W'(NOP);
        w_busy       = 1'b0;
        w_ld_ready   = 1'b0;
        w_prog_ok    = 1'b0;
        case (r_state)
            CLEAR: begin
                w_busy  = 1'b1;
                w_we    = 1'b1;
                w_waddr = r_clr_ptr;
                if (r_clr_ptr == IW'(DEPTH - 1)) begin
                    w_state_next = LOAD;
                end
            end
            LOAD: begin
                w_ld_ready = 1'b1;
                w_we       = LD_VALID;
                w_waddr    = LD_ADDR;
                w_wdata    = LD_DATA;
                if (LD_VALID && LD_LAST) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_prog_ok = 1'b1;
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    // Clear sweep pointer and saturating count of accepted load beats.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clr_ptr <= '0;
            r_ld_cnt  <= '0;
        end else begin
            if (r_state == CLEAR) begin
                r_clr_ptr <= r_clr_ptr + IW'(1);
            end
            if ((r_state == LOAD) && LD_VALID && (r_ld_cnt != (IW + 1)'(DEPTH))) begin
                r_ld_cnt <= r_ld_cnt + (IW + 1)'(1);
            end
        end
    end

    // Fetches return real instructions only once the program is committed.
    assign w_q = ((r_state == RUN) && !w_oor && !w_mis) ? w_rdata : DATA_W'(NOP);

    generate
        if (READ_REG != 0) begin : g_read_reg
            logic [DATA_W-1:0] r_q;
            logic              r_mis;
            logic              r_oor;

            // One-cycle fetch pipeline; data and flags stay aligned.
            always_ff @(posedge CLK) begin
                if (RESET) begin
                    r_q   <= DATA_W'(NOP);
                    r_mis <= 1'b0;
                    r_oor <= 1'b0;
                end else begin
                    r_q   <= w_q;
                    r_mis <= w_mis;
                    r_oor <= w_oor;
                end
            end

            assign Q        = r_q;
            assign MISALIGN = r_mis;
            assign OOR      = r_oor;
        end else begin : g_read_comb
            assign Q        = w_q;
            assign MISALIGN = w_mis;
            assign OOR      = w_oor;
        end
    endgenerate

    assign BUSY     = w_busy;
    assign LD_READY = w_ld_ready;
    assign PROG_OK  = w_prog_ok;
    assign LD_CNT   = r_ld_cnt;

endmodule
